if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; drives the IF/ID boundary consumed by the decode stage.
//  Owns the PC register, next-PC selection (PC+4 / branch / jump) and a req/ready instruction-memory handshake.
//  Owns the IF/ID pipeline register, with stall hold, redirect squash and a one-entry buffer for stalled fetches.
//  Consumes branch/jump target and select signals from decode; produces PC+4 and IR for decode.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble instruction inserted on flush/empty (decodes to all-zero controls)
// PORTS
//  Clk            in   1   pipeline clock, all state updates on posedge
//  Rst_n          in   1   reset, synchronous, active-low
//  In_BranchPC    in   32  branch target from decode
//  In_JumpPC      in   32  jump target from decode
//  In_PCSrc       in   1   branch taken (from decode)
//  In_Jump        in   1   jump (from decode)
//  In_Stall       in   1   hazard unit: hold PC and IF/ID
//  Out_IMemAddr   out  32  fetch address (= PC)
//  Out_IMemReq    out  1   fetch request
//  In_IMemData    in   32  instruction word, valid when In_IMemReady=1
//  In_IMemReady   in   1   memory accepts request / returns data this cycle
//  Out_PC         out  32  PC+4 of instruction in IF/ID (decode adds SE<<2 to this)
//  Out_IR         out  32  instruction in IF/ID; NOP_INSTR when not valid
//  Out_Valid      out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): PC=RESET_PC, state=FETCH, Out_IR=NOP_INSTR, Out_PC=RESET_PC+4, Out_Valid=0,
//   buffer empty, pending redirect cleared; Out_IMemReq=0 during the reset cycle; In_IMemReady ignored. Reset
//   mid-request abandons the request.
//  Handshake: Out_IMemReq=1 in FETCH/DRAIN; Out_IMemAddr stable while Req=1 and Ready=0; transfer completes on
//   a posedge with Req=1 and Ready=1. Any number of wait cycles allowed; no timeout.
//  Redirect = (In_PCSrc | In_Jump) & Out_Valid & ~In_Stall; target = In_Jump ? In_JumpPC : In_BranchPC (jump wins).
//  Stall has priority over redirect (decode's decision is invalid while stalled).
//  States: FETCH, HOLD, DRAIN.
//  FETCH:
//   - Redirect & Ready: drop data, PC<=target, IF/ID<=NOP (Valid=0), stay FETCH.
//   - Redirect & ~Ready: latch target, IF/ID<=NOP, ->DRAIN.
//   - Ready & ~Stall: IF/ID<={PC+4,Data,Valid=1}, PC<=PC+4.
//   - Ready & Stall: buffer<={PC+4,Data}, PC<=PC+4, IF/ID held, ->HOLD.
//   - ~Ready: IF/ID<=NOP if ~Stall, else held.
//  HOLD: Req=0.
//   - Redirect: buffer cleared, PC<=target, IF/ID<=NOP, ->FETCH.
//   - ~Stall: IF/ID<=buffer (Valid=1), ->FETCH.
//   - Stall: everything held.
//  DRAIN: Req=1 on old address; on Ready discard data, PC<=latched target, ->FETCH. Further redirects in DRAIN
//   are impossible (IF/ID holds NOP).
//  Throughput: 1 instr/cycle when Ready held high; load-to-Out_IR latency 1 cycle after transfer.
//  PC arithmetic is mod 2^32 (0xFFFF_FFFC+4 -> 0); low 2 address bits passed through unchecked.
// STRUCTURE
//  Shared package mips_pkg: NOP_INSTR, RESET_PC default, state encoding (FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2).
//  One sub-module: if_id_reg (32b PC + 32b IR + valid; load / hold / flush-to-NOP, sync active-low reset).
//  Next-PC mux, FSM and buffer live in if_stage.
// TESTING
//  1 Ready tied 1, 4 sequential words, no stall -> Out_PC 4,8,12,16 on consecutive cycles, Valid=1 each.
//  2 Ready low 3 cycles for addr 0x8 -> Addr held 0x8, Out_IR=NOP/Valid=0 for 3 cycles, then word appears.
//  3 Stall 2 cycles coincident with Ready -> IF/ID unchanged, word buffered, released in order after stall.
//  4 Branch instr in IF/ID, PCSrc=1, BranchPC=0x40 -> next fetch at 0x40, following IF/ID is NOP, Valid=0.
//  5 PCSrc=1 and Jump=1, JumpPC=0x100, BranchPC=0x40 -> fetch 0x100; with Stall=1 -> no redirect.
//  6 Redirect while Ready=0 (DRAIN), then Rst_n=0 mid-request -> PC=RESET_PC, Req=0, Valid=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: bubble instruction, reset PC
// default, fetch-FSM state encoding and PC increment helper.
package mips_pkg;

    // All-zero word decodes to all-zero controls (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding on PC
        HOLD  = 2'd1,   // fetched word parked in buffer while decode stalls
        DRAIN = 2'd2    // redirect seen mid-request; finish old request, then jump
    } fetch_state_e;

    // Sequential PC step; wraps mod 2^32, low two bits passed through.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: PC+4, instruction word and valid flag.
// Flush turns the entry into a bubble (IR=NOP, valid=0); load captures a
// new entry; otherwise the entry is held.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        flush_en,
    input  logic [31:0] pc_next,
    input  logic [31:0] ir_next,
    output logic [31:0] pc_reg,
    output logic [31:0] ir_reg,
    output logic        valid_reg
);

    // Register update: reset, then flush beats load, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC + 32'd4;
            ir_reg    <= NOP_WORD;
            valid_reg <= 1'b0;
        end else if (flush_en) begin
            ir_reg    <= NOP_WORD;
            valid_reg <= 1'b0;
        end else if (load_en) begin
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            valid_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, req/ready
// instruction-memory handshake, one-entry stall buffer and the IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] In_BranchPC,
    input  logic [31:0] In_JumpPC,
    input  logic        In_PCSrc,
    input  logic        In_Jump,
    input  logic        In_Stall,
    output logic [31:0] Out_IMemAddr,
    output logic        Out_IMemReq,
    input  logic [31:0] In_IMemData,
    input  logic        In_IMemReady,
    output logic [31:0] Out_PC,
    output logic [31:0] Out_IR,
    output logic        Out_Valid
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pc_inc;
    logic [31:0]  target;
    logic [31:0]  target_reg, target_next;
    logic [31:0]  buf_pc_reg, buf_pc_next;
    logic [31:0]  buf_ir_reg, buf_ir_next;
    logic         redirect;
    logic         ifid_load, ifid_flush;
    logic [31:0]  ifid_pc, ifid_ir;

    // Decode's branch/jump decision only counts for a real, unstalled instruction.
    assign redirect = (In_PCSrc | In_Jump) & Out_Valid & ~In_Stall;
    assign target   = In_Jump ? In_JumpPC : In_BranchPC;
    assign pc_inc   = pc_plus4(pc_reg);

    // The fetch address is the PC itself, so it cannot move while a request waits.
    assign Out_IMemAddr = pc_reg;
    assign Out_IMemReq  = Rst_n & ((state_reg == FETCH) | (state_reg == DRAIN));

    // Next-state, next-PC, buffer and IF/ID control for the fetch FSM.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        buf_pc_next = buf_pc_reg;
        buf_ir_next = buf_ir_reg;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_pc     = pc_inc;
        ifid_ir     = In_IMemData;
        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (In_IMemReady) begin
                        pc_next = target;
                    end else begin
                        // Memory still owes us the old word; remember where to go.
                        target_next = target;
                        state_next  = DRAIN;
                    end
                end else if (In_IMemReady) begin
                    pc_next = pc_inc;
                    if (!In_Stall) begin
                        ifid_load = 1'b1;
                    end else begin
                        buf_pc_next = pc_inc;
                        buf_ir_next = In_IMemData;
                        state_next  = HOLD;
                    end
                end else if (!In_Stall) begin
                    ifid_flush = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_ir_next = NOP_INSTR;
                    ifid_flush  = 1'b1;
                    pc_next     = target;
                    state_next  = FETCH;
                end else if (!In_Stall) begin
                    ifid_load  = 1'b1;
                    ifid_pc    = buf_pc_reg;
                    ifid_ir    = buf_ir_reg;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                // IF/ID already holds a bubble; keep it that way.
                ifid_flush = ~In_Stall;
                if (In_IMemReady) begin
                    pc_next    = target_reg;
                    state_next = FETCH;
                end
            end
            default: begin
                ifid_flush = 1'b1;
                state_next = FETCH;
            end
        endcase
    end

    // State, PC, redirect target and stall buffer registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            target_reg <= RESET_PC;
            buf_pc_reg <= RESET_PC + 32'd4;
            buf_ir_reg <= NOP_INSTR;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            buf_pc_reg <= buf_pc_next;
            buf_ir_reg <= buf_ir_next;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_INSTR)
    ) u_if_id (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load_en   (ifid_load),
        .flush_en  (ifid_flush),
        .pc_next   (ifid_pc),
        .ir_next   (ifid_ir),
        .pc_reg    (Out_PC),
        .ir_reg    (Out_IR),
        .valid_reg (Out_Valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage. The bench plays instruction memory and decode. A
// program-order model predicts which address decode must see next: after
// consuming the instruction at A it is A+4, or the effective branch/jump
// target. Stimulus pushes each prediction; a negedge monitor pops and
// compares whenever decode actually consumes an instruction.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] In_BranchPC, In_JumpPC;
    logic        In_PCSrc, In_Jump, In_Stall;
    logic [31:0] Out_IMemAddr;
    logic        Out_IMemReq;
    logic [31:0] In_IMemData;
    logic        In_IMemReady;
    logic [31:0] Out_PC, Out_IR;
    logic        Out_Valid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_last;

    always #5 Clk = ~Clk;

    // Memory image: odd multiplier is a bijection on aligned addresses, |1 keeps it non-NOP.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) | 32'd1;
    endfunction

    assign In_IMemData = In_IMemReady ? memword(Out_IMemAddr) : 32'hBAD0_0BAD;

    if_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .In_BranchPC  (In_BranchPC),
        .In_JumpPC    (In_JumpPC),
        .In_PCSrc     (In_PCSrc),
        .In_Jump      (In_Jump),
        .In_Stall     (In_Stall),
        .Out_IMemAddr (Out_IMemAddr),
        .Out_IMemReq  (Out_IMemReq),
        .In_IMemData  (In_IMemData),
        .In_IMemReady (In_IMemReady),
        .Out_PC       (Out_PC),
        .Out_IR       (Out_IR),
        .Out_Valid    (Out_Valid)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Apply one cycle of inputs and record the model's prediction.
    task automatic drive(input bit rst, input bit ready, input bit stall, input bit pcsrc,
                         input bit jump, input logic [31:0] bpc, input logic [31:0] jpc);
        logic [31:0] nxt;
        Rst_n        = ~rst;
        In_IMemReady = ready;
        In_Stall     = stall;
        In_PCSrc     = pcsrc;
        In_Jump      = jump;
        In_BranchPC  = bpc;
        In_JumpPC    = jpc;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            exp_last = RESET_PC;
        end else if (Out_Valid === 1'b1 && !stall) begin
            // Decode consumes its instruction this cycle: program order decides what follows.
            if (jump)       nxt = jpc;
            else if (pcsrc) nxt = bpc;
            else            nxt = exp_last + 32'd4;
            exp_q.push_back(nxt);
            exp_last = nxt;
        end
    endtask

    task automatic step(input bit rst, input bit ready, input bit stall, input bit pcsrc,
                        input bit jump, input logic [31:0] bpc, input logic [31:0] jpc);
        drive(rst, ready, stall, pcsrc, jump, bpc, jpc);
        @(posedge Clk);
        #1;
    endtask

    // Monitor: scoreboard pops on consumption, bubble and address-hold checks.
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    int          idle = 0;
    always @(negedge Clk) begin
        logic [31:0] a;
        if (Rst_n === 1'b1) begin
            if (Out_Valid === 1'b1 && In_Stall === 1'b0) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty actual_pc=%h required=no_instruction", Out_PC);
                end else begin
                    a = exp_q.pop_front();
                    check32("sb_pc", Out_PC, a + 32'd4);
                    check32("sb_ir", Out_IR, memword(a));
                end
            end else begin
                idle++;
            end
            if (Out_Valid !== 1'b1) check32("bubble_ir", Out_IR, NOP);
            if (prev_wait) check32("addr_hold", Out_IMemAddr, prev_addr);
            if (idle > 400) begin
                checks++;
                failures++;
                $display("FAIL watchdog actual=no_consume_400_cycles required=progress");
                idle = 0;
            end
        end else begin
            idle = 0;
        end
        prev_wait = (Rst_n === 1'b1) && (Out_IMemReq === 1'b1) && (In_IMemReady === 1'b0);
        prev_addr = Out_IMemAddr;
    end

    initial begin
        // Reset: request low during reset, clean IF/ID afterwards.
        drive(1, 1, 0, 0, 0, '0, '0);
        #1;
        check32("rst_req", {31'd0, Out_IMemReq}, 32'd0);
        @(posedge Clk); #1;
        step(1, 1, 0, 0, 0, '0, '0);
        check32("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check32("rst_pc", Out_PC, RESET_PC + 32'd4);
        check32("rst_ir", Out_IR, NOP);
        check32("rst_addr", Out_IMemAddr, RESET_PC);

        // 1: back-to-back fetch at full throughput.
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 0, '0, '0);
            check32("t1_pc", Out_PC, 32'(4 * i));
            check32("t1_valid", {31'd0, Out_Valid}, 32'd1);
        end

        // 2: three wait states on address 0x8.
        step(1, 1, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, '0, '0);
            check32("t2_addr", Out_IMemAddr, 32'h8);
            check32("t2_valid", {31'd0, Out_Valid}, 32'd0);
        end
        step(0, 1, 0, 0, 0, '0, '0);
        check32("t2_pc", Out_PC, 32'hC);
        check32("t2_ir", Out_IR, memword(32'h8));

        // 3: two stall cycles coincident with Ready; buffered word released after.
        step(0, 1, 1, 0, 0, '0, '0);
        check32("t3_hold_pc", Out_PC, 32'hC);
        check32("t3_hold_req", {31'd0, Out_IMemReq}, 32'd0);
        step(0, 1, 1, 0, 0, '0, '0);
        check32("t3_hold_pc2", Out_PC, 32'hC);
        step(0, 0, 0, 0, 0, '0, '0);
        check32("t3_rel_pc", Out_PC, 32'h10);
        check32("t3_rel_ir", Out_IR, memword(32'hC));
        step(0, 1, 0, 0, 0, '0, '0);
        check32("t3_next_pc", Out_PC, 32'h14);

        // 4: taken branch to 0x40.
        step(0, 1, 0, 1, 0, 32'h40, 32'h0);
        check32("t4_valid", {31'd0, Out_Valid}, 32'd0);
        check32("t4_addr", Out_IMemAddr, 32'h40);
        step(0, 1, 0, 0, 0, '0, '0);
        check32("t4_pc", Out_PC, 32'h44);

        // 5: stall masks redirect; then jump wins over branch.
        step(0, 1, 1, 1, 1, 32'h40, 32'h100);
        check32("t5_stall_pc", Out_PC, 32'h44);
        check32("t5_stall_addr", Out_IMemAddr, 32'h48);
        step(0, 1, 0, 1, 1, 32'h40, 32'h100);
        check32("t5_jump_addr", Out_IMemAddr, 32'h100);
        check32("t5_jump_valid", {31'd0, Out_Valid}, 32'd0);
        step(0, 1, 0, 0, 0, '0, '0);
        check32("t5_pc", Out_PC, 32'h104);

        // 6: redirect while memory waits, then reset mid-request.
        step(0, 0, 0, 0, 1, 32'h0, 32'h200);
        check32("t6_drain_addr", Out_IMemAddr, 32'h104);
        check32("t6_drain_req", {31'd0, Out_IMemReq}, 32'd1);
        step(0, 0, 0, 0, 0, '0, '0);
        check32("t6_drain_addr2", Out_IMemAddr, 32'h104);
        drive(1, 1, 0, 0, 0, '0, '0);
        #1;
        check32("t6_rst_req", {31'd0, Out_IMemReq}, 32'd0);
        @(posedge Clk); #1;
        check32("t6_rst_addr", Out_IMemAddr, RESET_PC);
        check32("t6_rst_valid", {31'd0, Out_Valid}, 32'd0);
        step(0, 0, 0, 0, 0, '0, '0);
        check32("t6_req", {31'd0, Out_IMemReq}, 32'd1);

        // PC wrap at the top of the address space.
        step(0, 1, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 1, 32'h0, 32'hFFFF_FFF8);
        step(0, 1, 0, 0, 0, '0, '0);
        check32("wrap_pc1", Out_PC, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, '0, '0);
        check32("wrap_pc2", Out_PC, 32'h0000_0000);
        step(0, 1, 0, 0, 0, '0, '0);
        check32("wrap_pc3", Out_PC, 32'h0000_0004);

        // Random traffic against the program-order model.
        for (int c = 0; c < 3000; c++) begin
            bit rst, rdy, stl, br, jp;
            rst = ($urandom_range(0, 399) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            stl = ($urandom_range(0, 9) < 2);
            br  = ($urandom_range(0, 99) < 15);
            jp  = ($urandom_range(0, 99) < 8);
            step(rst, rdy, stl, br, jp, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end
        for (int c = 0; c < 8; c++) step(0, 1, 0, 0, 0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
